inner_product_stream_ctrl: RTL and testbench
============================================

# inner_product_stream_ctrl

Sequential front/back end for the combinational 3-element inner-product core. Accepts 8-bit elements one per handshake on a valid/ready stream and packs them into two 24-bit vectors. It registers the 18-bit core result and returns it on a valid/ready output stream. Optionally, it accumulates results across groups so that longer vectors can be processed.

## Interface
Parameters:
- ACC_W, 24, accumulator and out_data width (>= 18).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  8  unsigned element; order per group a0,b0,a1,b1,a2,b2.
- in_last  in  1  sampled only with b2; marks last group of a frame.
- out_valid  out  1  out_data valid; held until accepted.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  ACC_W  result, zero-extended.
- out_ovf  out  1  accumulator wrapped during this frame.
- busy  out  1  high in any state but LOAD with byte count 0.

## Operation
- States: LOAD, CALC, OUT.
- LOAD
  - in_ready=1.
  - Each accepted byte is written into a or b slot by a 3-bit count (0..5); even count goes to a[8k+7:8k] and odd count goes to b, with k=count/2.
  - Acceptance at count 5 captures in_last, clears count and moves to CALC.
- CALC (1 cycle)
  - in_ready=0.
  - Core output p (18 bit, max 3*255*255=195075) is registered.
  - Without accumulation: result=p, go to OUT.
  - With accumulation: sum=acc+p modulo 2^ACC_W, and a carry-out sets ovf.
    - If the captured last=0: acc<=sum, go to LOAD.
    - Otherwise: result=sum, go to OUT.
- OUT
  - out_valid=1 with stable out_data/out_ovf until out_valid&&out_ready.
  - On that cycle: acc<=0, ovf<=0, go to LOAD; in_ready=0 throughout OUT.
- Reset values: state LOAD, count 0, a/b vectors 0, acc 0, ovf 0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_ovf=0, busy=0.
- Reset mid-operation: partial bytes, pending result and accumulator are discarded; no out_valid is produced for them.
- in_valid with in_ready=0 is ignored; the source must hold the data.

## Timing
- 6th byte accepted at cycle N: CALC at N+1, out_valid at N+2.
- Minimum group period without accumulation: 8 cycles (6 LOAD + CALC + OUT with out_ready=1).
- With accumulation, non-last groups take 7 cycles.
- out_ready asserted before out_valid costs nothing; out_valid never drops without a handshake.
- out_data is a register output; no combinational path from in_data or out_ready to out_* .

## Configuration
- INNER_PRODUCT_STREAM_ACC_EN defined:
  - Accumulator and ovf logic are present, and in_last delimits frames.
  - out_data=sum over groups, and out_ovf reports a wrap.
- Undefined:
  - in_last is ignored and there is no accumulator.
  - Every group yields one output with out_data=p zero-extended, and out_ovf tied 0.

## Structure
- Shared package: state encoding (LOAD/CALC/OUT), ELEM_W=8, VEC_N=3, P_W=18.
- One sub-module: instantiate the existing inner_product_3_elements core, fed by the packed a/b registers.
- The FSM, packer and accumulator are in this module.

## Test plan
- Bytes 15,15,15,15,15,15 with out_ready=1 → out_data=675 exactly 2 cycles after the 6th accept; out_ovf=0.
- All bytes 255 → out_data=195075. Bytes a={1,2,3}, b={4,5,6} → 32.
- out_ready held 0 for 5 cycles → out_valid and out_data=675 stable; in_ready=0; the next group is accepted only after the handshake.
- ACC_EN, ACC_W=24, two groups of 255s with in_last on the second → single output 390150, ovf=0; no output after the first group.
- ACC_EN, ACC_W=18, same stimulus → out_data=128006, out_ovf=1; the next frame of 15s gives 675, ovf=0.
- rst pulsed after 3 bytes, then a full group of 15s → one output 675; busy=0 and in_ready=1 in the cycle after reset.

Source files
------------

// File: rtl/inner_product_stream_ctrl_pkg.sv
// Shared definitions for the inner-product stream controller and its core.
// Build option: INNER_PRODUCT_STREAM_ACC_EN enables cross-group accumulation in the top.
package inner_product_stream_ctrl_pkg;

  localparam int unsigned ELEM_W = 8;
  localparam int unsigned VEC_N  = 3;
  localparam int unsigned P_W    = 18;
  localparam int unsigned VEC_W  = ELEM_W * VEC_N;
  localparam int unsigned CNT_W  = 3;

  // Byte index of b2, the last element of a group.
  localparam logic [CNT_W-1:0] LAST_CNT = 3'd5;

  typedef enum logic [1:0] {
    StLoad,
    StCalc,
    StOut
  } state_e;

endpackage

// File: rtl/inner_product_3_elements.sv
// Combinational 3-element inner product of two packed vectors of 8-bit unsigned elements.
module inner_product_3_elements
  import inner_product_stream_ctrl_pkg::*;
(
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic [P_W-1:0]   p
);

  always_comb begin
    p = '0;
    for (int k = 0; k < VEC_N; k++) begin
      p = p + P_W'(a[k*ELEM_W +: ELEM_W]) * P_W'(b[k*ELEM_W +: ELEM_W]);
    end
  end

endmodule

// File: rtl/inner_product_stream_ctrl.sv
// Byte-stream packer, result register and optional accumulator around the inner-product core.
// Build option: INNER_PRODUCT_STREAM_ACC_EN accumulates groups until in_last closes a frame.
module inner_product_stream_ctrl
  import inner_product_stream_ctrl_pkg::*;
#(
  parameter int unsigned ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [VEC_W-1:0]   a_q, a_d;
  logic [VEC_W-1:0]   b_q, b_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic [P_W-1:0]     p;
  logic               accept;
  logic               group_done;

  inner_product_3_elements u_core (
    .a (a_q),
    .b (b_q),
    .p (p)
  );

  assign in_ready   = (state_q == StLoad);
  assign accept     = in_valid && in_ready;
  assign group_done = accept && (count_q == LAST_CNT);
  assign out_valid  = (state_q == StOut);
  assign out_data   = result_q;
  assign busy       = !((state_q == StLoad) && (count_q == '0));

  // Even byte index lands in a, odd in b, element slot k = count/2.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    count_d = count_q;
    if (accept) begin
      for (int k = 0; k < VEC_N; k++) begin
        if (int'(count_q[2:1]) == k) begin
          if (!count_q[0]) begin
            a_d[k*ELEM_W +: ELEM_W] = in_data;
          end else begin
            b_d[k*ELEM_W +: ELEM_W] = in_data;
          end
        end
      end
      count_d = group_done ? '0 : count_q + 3'd1;
    end
  end

`ifdef INNER_PRODUCT_STREAM_ACC_EN
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             last_q, last_d;
  logic [ACC_W:0]   sum;

  // Extra top bit is the carry-out that flags a wrap.
  assign sum     = {1'b0, acc_q} + (ACC_W+1)'(p);
  assign out_ovf = ovf_q;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    last_d   = last_q;
    case (state_q)
      StLoad: begin
        if (group_done) begin
          last_d  = in_last;
          state_d = StCalc;
        end
      end
      StCalc: begin
        ovf_d = ovf_q | sum[ACC_W];
        if (!last_q) begin
          acc_d   = sum[ACC_W-1:0];
          state_d = StLoad;
        end else begin
          result_d = sum[ACC_W-1:0];
          state_d  = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      last_q <= last_d;
    end
  end
`else
  logic unused_last;

  assign unused_last = in_last;
  assign out_ovf     = 1'b0;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    case (state_q)
      StLoad: begin
        if (group_done) begin
          state_d = StCalc;
        end
      end
      StCalc: begin
        result_d = ACC_W'(p);
        state_d  = StOut;
      end
      StOut: begin
        if (out_ready) begin
          state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StLoad;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_inner_product_stream_ctrl.sv
// Directed bench for inner_product_stream_ctrl: vector table plus stall, reset and frame sequences.
module tb_inner_product_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_ovf;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;

  typedef struct {
    logic [47:0] bytes;  // byte j at [8j+7:8j], order a0,b0,a1,b1,a2,b2
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [7];

  inner_product_stream_ctrl #(.ACC_W(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

`ifdef INNER_PRODUCT_STREAM_ACC_EN
  logic        in_ready18;
  logic        out_valid18;
  logic [17:0] out_data18;
  logic        out_ovf18;
  logic        busy18;

  inner_product_stream_ctrl #(.ACC_W(18)) dut18 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready18),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid18),
    .out_ready (out_ready),
    .out_data  (out_data18),
    .out_ovf   (out_ovf18),
    .busy      (busy18)
  );
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 expected in_ready=1 within 50 cycles");
    end
    @(posedge clk);
    accept_cyc = cyc;
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_group(input logic [47:0] bytes, input logic l);
    for (int j = 0; j < 6; j++) begin
      send_byte(bytes[8*j +: 8], l);
    end
  endtask

  // Returns at a falling edge inside the OUT cycle.
  task automatic wait_out(input string name, input logic [23:0] exp_d, input logic exp_o);
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got out_valid=0 expected out_valid=1 within 50 cycles", name);
    end else begin
      check({name, "_latency"}, cyc - accept_cyc, 2);
      check({name, "_data"}, out_data, exp_d);
      check({name, "_ovf"}, out_ovf, exp_o);
    end
  endtask

  initial begin
    vecs[0] = '{48'h0f0f0f0f0f0f, 24'd675};
    vecs[1] = '{48'hffffffffffff, 24'd195075};
    vecs[2] = '{48'h060305020401, 24'd32};
    vecs[3] = '{48'h070908080907, 24'd190};
    vecs[4] = '{48'h00000000140a, 24'd200};
    vecs[5] = '{48'h0000000001ff, 24'd255};
    vecs[6] = '{48'h000000000000, 24'd0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      send_group(vecs[i].bytes, 1'b1);
      wait_out($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
    end

    // Downstream stall: output held, input blocked, stray valid ignored.
    @(negedge clk);
    out_ready = 1'b0;
    send_group(48'h0f0f0f0f0f0f, 1'b1);
    wait_out("stall", 24'd675, 1'b0);
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'd99;
      check($sformatf("stall%0d_valid", s), out_valid, 1);
      check($sformatf("stall%0d_data", s), out_data, 675);
      check($sformatf("stall%0d_in_ready", s), in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_hs_valid", out_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    send_group(48'h060305020401, 1'b1);
    wait_out("after_stall", 24'd32, 1'b0);

    // Reset in the middle of a group discards the partial bytes.
    send_byte(8'd200, 1'b1);
    send_byte(8'd200, 1'b1);
    send_byte(8'd200, 1'b1);
    @(negedge clk);
    check("partial_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    send_group(48'h0f0f0f0f0f0f, 1'b1);
    wait_out("midrst", 24'd675, 1'b0);
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      check($sformatf("midrst_quiet%0d", s), out_valid, 0);
    end

`ifdef INNER_PRODUCT_STREAM_ACC_EN
    send_group(48'hffffffffffff, 1'b0);
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      check($sformatf("acc_noout%0d", s), out_valid, 0);
      check($sformatf("acc18_noout%0d", s), out_valid18, 0);
    end
    send_group(48'hffffffffffff, 1'b1);
    wait_out("acc24", 24'd390150, 1'b0);
    check("acc18_valid", out_valid18, 1);
    check("acc18_data", out_data18, 128006);
    check("acc18_ovf", out_ovf18, 1);
    send_group(48'h0f0f0f0f0f0f, 1'b1);
    wait_out("acc24_next", 24'd675, 1'b0);
    check("acc18_next_data", out_data18, 675);
    check("acc18_next_ovf", out_ovf18, 0);
`else
    // in_last ignored: every group yields its own result.
    send_group(48'hffffffffffff, 1'b0);
    wait_out("nolast0", 24'd195075, 1'b0);
    send_group(48'hffffffffffff, 1'b1);
    wait_out("nolast1", 24'd195075, 1'b0);
    send_group(48'h0f0f0f0f0f0f, 1'b0);
    wait_out("nolast2", 24'd675, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
